// File: rtl/emon_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : emon_irq_ctrl
// Description : Interrupt controller for the emon event counters. Detects
//               rising edges on the per-counter zero flags, latches them into
//               sticky STATUS bits, masks them and drives one host interrupt
//               in level or pulse mode. Registers on the reg_* bus:
//                 addr 0 STATUS  (W1C)   addr 1 MASK (RW)
//                 addr 2 CONFIG  (bit0: 0=level, 1=pulse)
//                 addr 3 HOLDOFF (16-bit RW)
// Ports       : clk, reset (sync, active-high)
//               emon_zero_flag[NCNT] - zero flags from counters
//               reg_write, reg_addr[2], reg_data[DW] - register write bus
//               reg_rdata[DW]  - registered read data for reg_addr
//               emon_irq       - interrupt to host
// Options     : EMON_IRQ_HOLDOFF_EN - adds a HOLD state and 16-bit down-counter
//               that spaces out pulse-mode interrupts by HOLDOFF cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module emon_irq_ctrl #(
    parameter int NCNT = 4,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCNT-1:0] emon_zero_flag,
    input  logic            reg_write,
    input  logic [1:0]      reg_addr,
    input  logic [DW-1:0]   reg_data,
    output logic [DW-1:0]   reg_rdata,
    output logic            emon_irq
);

    localparam logic [1:0] c_ADDR_STATUS  = 2'd0;
    localparam logic [1:0] c_ADDR_MASK    = 2'd1;
    localparam logic [1:0] c_ADDR_CONFIG  = 2'd2;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FIRE = 2'd1;
`ifdef EMON_IRQ_HOLDOFF_EN
    localparam logic [1:0] c_ST_HOLD = 2'd2;
`endif

    logic [NCNT-1:0] r_zero_q;
    logic [NCNT-1:0] r_status;
    logic [NCNT-1:0] r_mask;
    logic            r_mode;
    logic [15:0]     r_holdoff;
    logic [1:0]      r_state;
`ifdef EMON_IRQ_HOLDOFF_EN
    logic [15:0]     r_hold_cnt;
    logic            r_deferred;
    logic            w_defer_any;
`endif

    logic [NCNT-1:0] w_rise;
    logic [NCNT-1:0] w_w1c;
    logic [NCNT-1:0] w_status_nxt;
    logic            w_mrise;
    logic            w_pend;
    logic            w_wr_mask;
    logic            w_wr_cfg;
    logic            w_wr_hold;
    logic [DW-1:0]   w_rdata;
    logic            w_unused;

    // zero_q resets to ones so a flag already high out of reset is not an edge
    assign w_rise       = emon_zero_flag & ~r_zero_q;
    assign w_w1c        = (reg_write && (reg_addr == c_ADDR_STATUS)) ? reg_data[NCNT-1:0] : '0;
    // OR-ing the rise after the clear lets a same-cycle event beat W1C
    assign w_status_nxt = (r_status & ~w_w1c) | w_rise;
    assign w_mrise      = |(w_rise & r_mask);
    assign w_pend       = |(r_status & r_mask);
    assign w_wr_mask    = reg_write && (reg_addr == c_ADDR_MASK);
    assign w_wr_cfg     = reg_write && (reg_addr == c_ADDR_CONFIG);
    assign w_wr_hold    = reg_write && (reg_addr == 2'd3);
    assign w_unused     = ^reg_data;
`ifdef EMON_IRQ_HOLDOFF_EN
    // include an event arriving on the decision edge itself
    assign w_defer_any  = r_deferred | w_mrise;
`endif

    always_comb begin
        w_rdata = '0;
        case (reg_addr)
            c_ADDR_STATUS: w_rdata[NCNT-1:0] = r_status;
            c_ADDR_MASK:   w_rdata[NCNT-1:0] = r_mask;
            c_ADDR_CONFIG: w_rdata[0]        = r_mode;
            default:       w_rdata[15:0]     = r_holdoff;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero_q   <= '1;
            r_status   <= '0;
            r_mask     <= '0;
            r_mode     <= 1'b0;
            r_holdoff  <= '0;
            reg_rdata  <= '0;
            emon_irq   <= 1'b0;
            r_state    <= c_ST_IDLE;
`ifdef EMON_IRQ_HOLDOFF_EN
            r_hold_cnt <= '0;
            r_deferred <= 1'b0;
`endif
        end else begin
            r_zero_q  <= emon_zero_flag;
            r_status  <= w_status_nxt;
            reg_rdata <= w_rdata;   // sampled before this edge's W1C lands
            if (w_wr_mask) r_mask    <= reg_data[NCNT-1:0];
            if (w_wr_cfg)  r_mode    <= reg_data[0];
            if (w_wr_hold) r_holdoff <= reg_data[15:0];

            if (w_wr_cfg) begin
                // any CONFIG write restarts the interrupt path cleanly
                r_state  <= c_ST_IDLE;
                emon_irq <= 1'b0;
`ifdef EMON_IRQ_HOLDOFF_EN
                r_deferred <= 1'b0;
`endif
            end else if (!r_mode) begin
                r_state  <= c_ST_IDLE;
                emon_irq <= w_pend;
            end else begin
                // one output cycle per FIRE cycle
                emon_irq <= (r_state == c_ST_FIRE);
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_mrise) r_state <= c_ST_FIRE;
                    end
                    c_ST_FIRE: begin
                        if (w_mrise) begin
                            r_state <= c_ST_FIRE;
`ifdef EMON_IRQ_HOLDOFF_EN
                        end else if (r_holdoff != 16'd0) begin
                            r_state    <= c_ST_HOLD;
                            r_hold_cnt <= r_holdoff;
                            r_deferred <= 1'b0;
`endif
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
`ifdef EMON_IRQ_HOLDOFF_EN
                    c_ST_HOLD: begin
                        if (r_hold_cnt == 16'd1) begin
                            r_state    <= (w_defer_any && w_pend) ? c_ST_FIRE : c_ST_IDLE;
                            r_deferred <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 16'd1;
                            r_deferred <= w_defer_any;
                        end
                    end
`endif
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_emon_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_emon_irq_ctrl
// Description : Directed self-checking bench for emon_irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emon_irq_ctrl;

    localparam int NCNT = 4;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCNT-1:0] flags;
    logic            reg_write;
    logic [1:0]      reg_addr;
    logic [DW-1:0]   reg_data;
    logic [DW-1:0]   reg_rdata;
    logic            emon_irq;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    emon_irq_ctrl #(.NCNT(NCNT), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .emon_zero_flag (flags),
        .reg_write      (reg_write),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .reg_rdata      (reg_rdata),
        .emon_irq       (emon_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        reg_addr  = a;
        reg_data  = d;
        tick();
        reg_write = 1'b0;
        reg_addr  = 2'd0;
        reg_data  = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        reg_addr = a;
        tick();
    endtask

    initial begin
        logic exp_irq;
        reset     = 1'b1;
        flags     = 4'hF;
        reg_write = 1'b0;
        reg_addr  = 2'd0;
        reg_data  = '0;
        tick(); tick(); tick();
        check("rst_irq", {31'd0, emon_irq}, 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);

        // 1: flags high through reset exit produce no event
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_irq", {31'd0, emon_irq}, 32'd0);
        end
        check("t1_status", reg_rdata, 32'd0);

        // 2: level mode, mask bit 0
        wr(2'd1, 32'h1);
        flags = 4'h0; tick();
        flags = 4'h1; tick();
        check("t2_irq_k", {31'd0, emon_irq}, 32'd0);
        tick();
        check("t2_irq_k1", {31'd0, emon_irq}, 32'd1);
        check("t2_status", reg_rdata, 32'h1);
        reg_write = 1'b1; reg_addr = 2'd0; reg_data = 32'h1;
        tick();
        reg_write = 1'b0; reg_data = '0;
        check("t2_preclear", reg_rdata, 32'h1);
        check("t2_irq_w", {31'd0, emon_irq}, 32'd1);
        tick();
        check("t2_irq_w1", {31'd0, emon_irq}, 32'd0);
        check("t2_cleared", reg_rdata, 32'h0);

        // 3: masked-off event, then unmask
        wr(2'd1, 32'h2);
        flags = 4'h0; tick();
        flags = 4'h1; tick(); tick();
        check("t3_irq_masked", {31'd0, emon_irq}, 32'd0);
        check("t3_status", reg_rdata, 32'h1);
        wr(2'd1, 32'hFFFF_FFF3);
        check("t3_irq_m", {31'd0, emon_irq}, 32'd0);
        tick();
        check("t3_irq_m1", {31'd0, emon_irq}, 32'd1);
        rd(2'd1);
        check("t3_mask_rd", reg_rdata, 32'h3);

        // 4: rise on bit 1 on the same edge as its W1C
        reg_write = 1'b1; reg_addr = 2'd0; reg_data = 32'h2; flags = 4'h3;
        tick();
        reg_write = 1'b0; reg_data = '0;
        tick();
        check("t4_set_wins", reg_rdata, 32'h3);
        check("t4_irq", {31'd0, emon_irq}, 32'd1);
        wr(2'd0, 32'hF);
        tick();
        check("t4_clr_all", reg_rdata, 32'h0);
        check("t4_irq_off", {31'd0, emon_irq}, 32'd0);

        // 5: pulse mode, back-to-back events
        wr(2'd2, 32'hFFFF_FFFF);
        check("t5_cfg_irq", {31'd0, emon_irq}, 32'd0);
        rd(2'd2);
        check("t5_cfg_rd", reg_rdata, 32'h1);
        wr(2'd1, 32'hF);
        flags = 4'h0; tick();
        flags = 4'h1; tick();
        check("t5_irq_a", {31'd0, emon_irq}, 32'd0);
        flags = 4'h3; tick();
        check("t5_irq_a1", {31'd0, emon_irq}, 32'd1);
        tick();
        check("t5_irq_a2", {31'd0, emon_irq}, 32'd1);
        tick();
        check("t5_irq_a3", {31'd0, emon_irq}, 32'd0);
        rd(2'd0);
        check("t5_status", reg_rdata, 32'h3);
        tick();
        check("t5_no_level", {31'd0, emon_irq}, 32'd0);

        // 6: holdoff register and pulse spacing
        wr(2'd0, 32'hF);
        wr(2'd3, 32'h1234_5678);
        rd(2'd3);
        check("t6_hold_rd", reg_rdata, 32'h5678);
        wr(2'd3, 32'h8);
        flags = 4'h0; tick();
        flags = 4'h1; tick();
        check("t6_irq_t", {31'd0, emon_irq}, 32'd0);
        for (int n = 1; n <= 12; n++) begin
            if (n == 3) flags = 4'h5;
            tick();
`ifdef EMON_IRQ_HOLDOFF_EN
            exp_irq = (n == 1) || (n == 10);
`else
            exp_irq = (n == 1) || (n == 4);
`endif
            check($sformatf("t6_irq_t+%0d", n), {31'd0, emon_irq}, {31'd0, exp_irq});
        end

        // mode change back to level
        wr(2'd2, 32'h0);
        check("t7_cfg_force", {31'd0, emon_irq}, 32'd0);
        tick();
        check("t7_level_pend", {31'd0, emon_irq}, 32'd1);

        // reset mid-operation
        reset = 1'b1;
        tick();
        check("t8_rst_irq", {31'd0, emon_irq}, 32'd0);
        check("t8_rst_rdata", reg_rdata, 32'd0);
        reset = 1'b0;
        rd(2'd0);
        check("t8_status", reg_rdata, 32'd0);
        rd(2'd1);
        check("t8_mask", reg_rdata, 32'd0);
        rd(2'd3);
        check("t8_holdoff", reg_rdata, 32'd0);
        tick();
        check("t8_irq", {31'd0, emon_irq}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
